key_event: RTL and testbench

Converts the clean, synchronous key level from the debounce stage into one-cycle event pulses: press, release, short click, long press and auto-repeat. Sits between `debounce` and the user-interface logic (counters, menus, display control), so downstream logic never does its own edge detection or hold timing. Pure single-clock sequential block with a small FSM and one hold timer.

---
 rtl/key_event_pkg.sv | 26 ++
 rtl/key_event_if.sv | 23 ++
 rtl/key_event_hold_timer.sv | 32 +++
 rtl/key_event.sv | 116 +++++++++++
 tb/tb_key_event.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key front end: FSM state encodings, the bundle
// of one-cycle event pulses, and default time constants in clock cycles.
package key_event_pkg;

    localparam int unsigned KEY_NBITS = 27;

    // Default time constants at 100 MHz; the debounce stage uses the same table.
    localparam logic [KEY_NBITS-1:0] KEY_LONG_CYCLES   = 27'd100_000_000; // 1 s
    localparam logic [KEY_NBITS-1:0] KEY_REPEAT_CYCLES = 27'd20_000_000;  // 0.2 s
    localparam logic [KEY_NBITS-1:0] DEBOUNCE_CYCLES   = 27'd2_000_000;   // 20 ms

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    // One-cycle event pulses produced by key_event.
    typedef struct packed {
        logic press;
        logic rel;
        logic click;
        logic long_ev;
        logic rep;
    } key_pulses_t;

endpackage

// File: rtl/key_event_if.sv
// Key level in, event pulses and held level out. The master drives the
// debounced key level; the slave (key_event) produces the events.
interface key_event_if;

    logic key_i;
    logic press_o;
    logic release_o;
    logic click_o;
    logic long_o;
    logic repeat_o;
    logic held_o;

    modport master (
        output key_i,
        input  press_o, release_o, click_o, long_o, repeat_o, held_o
    );

    modport slave (
        input  key_i,
        output press_o, release_o, click_o, long_o, repeat_o, held_o
    );

endinterface

// File: rtl/key_event_hold_timer.sv
// Hold timer: free-running up-counter with synchronous clear and enable.
// tc flags the last cycle of a period of cmp cycles; cmp == 0 means no
// terminal count, and the counter then sticks at all-ones instead of wrapping.
module key_event_hold_timer #(
    parameter int unsigned NBITS = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [NBITS-1:0] cmp,
    output logic             tc
);

    logic [NBITS-1:0] cnt;

    assign tc = (cmp != '0) && (cnt == cmp - NBITS'(1));

    // Count while enabled; clear wins over enable; hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with <= so every register samples the values
        // from before this edge; blocking = here would create ordering races.
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + NBITS'(1);
        end
    end

endmodule

// File: rtl/key_event.sv
// Turns the debounced key level into one-cycle press, release, click,
// long-press and auto-repeat pulses plus a held level. All outputs are
// registered, so every event appears one clock after the edge that caused it.
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned      NBITS         = KEY_NBITS,
    parameter logic [NBITS-1:0] LONG_CYCLES   = NBITS'(KEY_LONG_CYCLES),
    parameter logic [NBITS-1:0] REPEAT_CYCLES = NBITS'(KEY_REPEAT_CYCLES)
) (
    input  logic           clk,
    input  logic           rst_n,
    key_event_if.slave     bus
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             key_q;
    key_pulses_t      pulses_q;
    key_pulses_t      pulses_nxt;
    logic             held_q;

    logic             tmr_clr;
    logic             tmr_en;
    logic [NBITS-1:0] tmr_cmp;
    logic             tmr_tc;

    key_event_hold_timer #(
        .NBITS (NBITS)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .cmp   (tmr_cmp),
        .tc    (tmr_tc)
    );

    // Next-state and event decode; a release always beats a timer terminal count.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        pulses_nxt = '0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_cmp    = LONG_CYCLES;

        case (state)
            ST_IDLE: begin
                // key_q is 0 out of reset, so a key already down counts as a press.
                if (bus.key_i && !key_q) begin
                    pulses_nxt.press = 1'b1;
                    tmr_clr          = 1'b1;
                    state_nxt        = ST_PRESSED;
                end
            end

            ST_PRESSED: begin
                tmr_cmp = LONG_CYCLES;
                if (!bus.key_i) begin
                    pulses_nxt.rel   = 1'b1;
                    pulses_nxt.click = 1'b1;
                    state_nxt        = ST_IDLE;
                end else if (tmr_tc) begin
                    pulses_nxt.long_ev = 1'b1;
                    tmr_clr            = 1'b1;
                    state_nxt          = ST_HELD;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_HELD: begin
                // A zero repeat period never raises tc; the timer just saturates.
                tmr_cmp = REPEAT_CYCLES;
                if (!bus.key_i) begin
                    pulses_nxt.rel = 1'b1;
                    state_nxt      = ST_IDLE;
                end else if (tmr_tc) begin
                    pulses_nxt.rep = 1'b1;
                    tmr_clr        = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, key history and registered outputs; reset aborts without a release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            key_q    <= 1'b0;
            pulses_q <= '0;
            held_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_q    <= bus.key_i;
            pulses_q <= pulses_nxt;
            held_q   <= (state_nxt == ST_HELD);
        end
    end

    assign bus.press_o   = pulses_q.press;
    assign bus.release_o = pulses_q.rel;
    assign bus.click_o   = pulses_q.click;
    assign bus.long_o    = pulses_q.long_ev;
    assign bus.repeat_o  = pulses_q.rep;
    assign bus.held_o    = held_q;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: two instances (repeat period 3 and repeat disabled,
// long press 8) share one key and reset. Every cycle both are compared with a
// timeline model that tracks only "is a press active and when did it start".
module tb_key_event;

    localparam int L = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_event_if bus_a ();
    key_event_if bus_b ();

    key_event #(
        .NBITS         (27),
        .LONG_CYCLES   (27'd8),
        .REPEAT_CYCLES (27'd3)
    ) u_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    key_event #(
        .NBITS         (27),
        .LONG_CYCLES   (27'd8),
        .REPEAT_CYCLES (27'd0)
    ) u_norep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per instance: 0 = repeat 3, 1 = repeat disabled.
    bit m_active [2];
    bit m_kq     [2];
    int m_start  [2];
    int m_rep    [2] = '{3, 0};

    // Pulse tallies per instance.
    int n_press [2];
    int n_rel   [2];
    int n_click [2];
    int n_long  [2];
    int n_rep   [2];

    typedef struct {
        logic       key;
        logic [5:0] exp;   // {press, release, click, long, repeat, held}
    } vec_t;

    vec_t vecs [16];

    function automatic logic [5:0] outs(input int i);
        if (i == 0)
            return {bus_a.press_o, bus_a.release_o, bus_a.click_o,
                    bus_a.long_o, bus_a.repeat_o, bus_a.held_o};
        return {bus_b.press_o, bus_b.release_o, bus_b.click_o,
                bus_b.long_o, bus_b.repeat_o, bus_b.held_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Event timeline for one clock edge: elapsed = cycles since the press edge.
    task automatic model_step(input int i, input logic k, output logic [5:0] e);
        int el;
        e = '0;
        if (!m_active[i]) begin
            if (k && !m_kq[i]) begin
                e[5]        = 1'b1;
                m_active[i] = 1'b1;
                m_start[i]  = cyc;
            end
        end else begin
            el = cyc - m_start[i];
            if (!k) begin
                e[4]        = 1'b1;
                e[3]        = (el <= L);
                m_active[i] = 1'b0;
            end else if (el == L) begin
                e[2] = 1'b1;
            end else if (m_rep[i] != 0 && el > L && ((el - L) % m_rep[i]) == 0) begin
                e[1] = 1'b1;
            end
        end
        m_kq[i] = k;
        e[0]    = m_active[i] && ((cyc - m_start[i]) >= L);
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < 2; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_click[i] = 0; n_long[i] = 0; n_rep[i] = 0;
        end
    endtask

    // One clock with key level k: drive at negedge, compare at the next negedge.
    task automatic cycle(input logic k);
        logic [5:0] e [2];
        logic [5:0] o;
        bus_a.key_i = k;
        bus_b.key_i = k;
        @(posedge clk);
        cyc++;
        model_step(0, k, e[0]);
        model_step(1, k, e[1]);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = outs(i);
            check(i == 0 ? "model_rep" : "model_norep", {26'd0, o}, {26'd0, e[i]});
            check("one_event", {31'd0, ($countones({o[5], o[4], o[2], o[1]}) <= 1)}, 32'd1);
            n_press[i] += int'(o[5]);
            n_rel[i]   += int'(o[4]);
            n_click[i] += int'(o[3]);
            n_long[i]  += int'(o[2]);
            n_rep[i]   += int'(o[1]);
        end
    endtask

    // Entered at a negedge; asserts reset between edges to show it is asynchronous.
    task automatic apply_reset(input int ncyc);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rep", {26'd0, outs(0)}, 32'd0);
        check("async_reset_norep", {26'd0, outs(1)}, 32'd0);
        repeat (ncyc) begin
            @(negedge clk);
            check("reset_hold_rep", {26'd0, outs(0)}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_kq[i]     = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] o;
        logic       k;
        int         run;

        bus_a.key_i = 1'b0;
        bus_b.key_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_kq[i] = 1'b0; m_start[i] = 0;
        end
        clear_tallies();

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_state_rep", {26'd0, outs(0)}, 32'd0);
        check("reset_state_norep", {26'd0, outs(1)}, 32'd0);
        rst_n = 1'b1;
        cycle(1'b0);
        cycle(1'b0);

        // Short press (4 cycles) followed by a 1/0 toggle every cycle.
        vecs[0] = '{1'b1, 6'b100000};
        vecs[1] = '{1'b1, 6'b000000};
        vecs[2] = '{1'b1, 6'b000000};
        vecs[3] = '{1'b1, 6'b000000};
        vecs[4] = '{1'b0, 6'b011000};
        vecs[5] = '{1'b0, 6'b000000};
        for (int i = 6; i < 16; i++)
            vecs[i] = (i % 2 == 0) ? '{1'b1, 6'b100000} : '{1'b0, 6'b011000};

        for (int i = 0; i < 16; i++) begin
            if (i == 6) clear_tallies();
            cycle(vecs[i].key);
            check("vec_rep", {26'd0, outs(0)}, {26'd0, vecs[i].exp});
            check("vec_norep", {26'd0, outs(1)}, {26'd0, vecs[i].exp});
        end
        check("toggle_press", n_press[0], 5);
        check("toggle_release", n_rel[0], 5);
        check("toggle_click", n_click[0], 5);
        cycle(1'b0);

        // Hold 20 cycles: long at P+8, repeats at P+11, P+14, P+17.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            o = outs(0);
            check("hold_press", {31'd0, o[5]}, {31'd0, (i == 0)});
            check("hold_long", {31'd0, o[2]}, {31'd0, (i == 8)});
            check("hold_repeat", {31'd0, o[1]}, {31'd0, (i == 11 || i == 14 || i == 17)});
            check("hold_held", {31'd0, o[0]}, {31'd0, (i >= 8)});
        end
        cycle(1'b0);
        o = outs(0);
        check("held_release", {31'd0, o[4]}, 32'd1);
        check("held_no_click", {31'd0, o[3]}, 32'd0);
        check("held_falls", {31'd0, o[0]}, 32'd0);
        cycle(1'b0);

        // Release exactly where the long press would fire: click wins.
        clear_tallies();
        repeat (8) cycle(1'b1);
        cycle(1'b0);
        o = outs(0);
        check("tc_release_click", {30'd0, o[4], o[3]}, 32'd3);
        check("tc_no_long_rep", n_long[0], 0);
        check("tc_no_long_norep", n_long[1], 0);
        cycle(1'b0);

        // Hold 40 cycles: repeat disabled gives one long and no repeats.
        clear_tallies();
        repeat (40) cycle(1'b1);
        check("norep_long", n_long[1], 1);
        check("norep_repeat", n_rep[1], 0);
        check("norep_held", {31'd0, outs(1) & 6'b1}, 32'd1);
        check("rep_count", n_rep[0], 10);
        cycle(1'b0);
        check("norep_release", {26'd0, outs(1)}, 32'b011000 & 32'b010000);
        cycle(1'b0);

        // Reset in HELD with the key still down: new press right after reset.
        repeat (12) cycle(1'b1);
        check("pre_reset_held", {31'd0, outs(0) & 6'b1}, 32'd1);
        apply_reset(2);
        cycle(1'b1);
        check("press_after_reset", {26'd0, outs(0)}, 32'b100000);
        cycle(1'b0);

        // Randomised key runs with occasional resets, checked against the model.
        k = 1'b0;
        for (int seg = 0; seg < 200; seg++) begin
            k   = ~k;
            run = $urandom_range(1, 25);
            for (int j = 0; j < run; j++) cycle(k);
            if ($urandom_range(0, 29) == 0) apply_reset(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
